// File: rtl/seq_adder_n.sv
// ============================================================================
// Module   : seq_adder_n
// Brief    : Digit-serial adder/subtractor, DIGIT bits per clock, with carry
//            out and signed overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_adder_n #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int c_n  = WIDTH / DIGIT;
    localparam int c_cw = (c_n > 1) ? $clog2(c_n) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_n - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_acc;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_b_eff;
    logic [DIGIT:0]   w_dsum;
    logic [WIDTH-1:0] w_a_acc_nxt;
    logic [WIDTH-1:0] w_b_nxt;

    assign w_b_eff = sub ? ~B : B;
    assign w_dsum  = {1'b0, r_a_acc[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                   + {{DIGIT{1'b0}}, r_carry};

    // Operand A drains out of the low digit while sum digits enter at the top,
    // so after N steps the same register holds the complete sum in place.
    generate
        if (c_n == 1) begin : g_single
            assign w_a_acc_nxt = w_dsum[DIGIT-1:0];
            assign w_b_nxt     = r_b;
        end else begin : g_multi
            assign w_a_acc_nxt = {w_dsum[DIGIT-1:0], r_a_acc[WIDTH-1:DIGIT]};
            assign w_b_nxt     = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_acc <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_acc <= A;
                        r_b     <= w_b_eff;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= w_b_eff[WIDTH-1];
                        r_carry <= sub ? 1'b1 : cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_a_acc <= w_a_acc_nxt;
                    r_b     <= w_b_nxt;
                    r_carry <= w_dsum[DIGIT];
                    if (r_cnt == c_last) begin
                        r_cnt   <= '0;
                        r_s     <= w_a_acc_nxt;
                        r_cout  <= w_dsum[DIGIT];
                        r_ovf   <= (r_a_msb == r_b_msb) &&
                                   (w_a_acc_nxt[WIDTH-1] != r_a_msb);
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign S    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;
    assign busy = r_busy;
    assign done = r_done;

endmodule

`default_nettype wire

// File: doc/seq_adder_n.md
SEQ_ADDER_N -- requirements
Module: seq_adder_n

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT (N = WIDTH/DIGIT digits).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; accepted on a rising edge when busy=0.
REQ-006 A  input  WIDTH  operand A; sampled only at an accepted start.
REQ-007 B  input  WIDTH  operand B; sampled only at an accepted start.
REQ-008 cin  input  1  carry-in; sampled only at an accepted start; ignored when sub=1.
REQ-009 sub  input  1  mode: 0 = A+B+cin, 1 = A-B (A + ~B + 1); sampled only at an accepted start.
REQ-010 S  output  WIDTH  registered result.
REQ-011 cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
REQ-012 ovf  output  1  two's-complement signed overflow of the operation.
REQ-013 busy  output  1  high while an operation is in progress.
REQ-014 done  output  1  single-cycle pulse marking S/cout/ovf valid.

Function
REQ-015 FSM states IDLE, RUN, DONE; busy=1 exactly in RUN.
REQ-016 IDLE or DONE with start=1: latch A, B (inverted if sub), carry = (sub ? 1 : cin), digit counter = 0, next state RUN.
REQ-017 IDLE with start=0: stay IDLE; DONE with start=0: go to IDLE.
REQ-018 RUN, each edge: add digit i of A, digit i of B and internal carry; write the DIGIT-bit sum into digit i of an internal accumulator; update carry; counter+1.
REQ-019 RUN, edge processing digit N-1: copy accumulator to S, final carry to cout, compute ovf; next state DONE.
REQ-020 ovf SHALL be 1 iff the MSBs of A and the effective B (after inversion) are equal and the MSB of S differs from them.
REQ-021 Latency: start accepted at edge k, done=1 in the cycle following edge k+N; result arithmetically equal to the WIDTH+1-bit sum {cout,S}.
REQ-022 done=1 only in DONE; asserted for exactly one cycle per operation.
REQ-023 S, cout, ovf SHALL hold their last value in IDLE, RUN and DONE until the next completion; never show partial sums.
REQ-024 start while busy=1 SHALL be ignored; no queuing; latched operands unaffected by input changes during RUN.
REQ-025 start in the DONE cycle SHALL be accepted (back-to-back throughput one operation per N+1 cycles).
REQ-026 DIGIT=WIDTH (N=1) SHALL be legal: one RUN cycle.

Reset
REQ-027 rst=1 at an edge: state IDLE; S=0, cout=0, ovf=0, busy=0, done=0; counter, carry and accumulator cleared.
REQ-028 rst has priority over start and over any RUN/DONE activity; an operation interrupted by reset SHALL produce no done pulse and no result update.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-029 A=0xB333, B=0x4444, cin=0, sub=0, start pulse -> busy high 4 cycles, done one cycle later; S=0xF777, cout=0, ovf=0.
REQ-030 A=0xFFFF, B=0xD555, cin=1, sub=0 -> S=0xD555, cout=1, ovf=0.
REQ-031 A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, cout=1, ovf=1; then A=0x7FFF, B=0x0001, sub=0, cin=0 -> S=0x8000, ovf=1.
REQ-032 start re-pulsed and A/B changed during RUN -> ignored, result of first operands; start in DONE cycle -> second operation begins, second done exactly N+1 cycles after first.
REQ-033 rst asserted on 2nd RUN cycle -> busy=0, done never pulses, S=0, cout=0, ovf=0 next cycle; new start afterwards completes normally.
REQ-034 Random sweep for DIGIT=1, 4, 16 (and WIDTH=32, DIGIT=8): {cout,S} matches reference A+B+cin / A-B, done latency N+1 edges.
